// File: rtl/ahb_multi_region_slave.sv
// AHB-lite slave fronting NUM_REGIONS 32-bit register-file regions with one decoder.
// Illegal accesses get a two-cycle ERROR response; legal data phases may be stretched by WAIT_STATES.
module ahb_multi_region_slave #(
  parameter int          NUM_REGIONS      = 4,
  parameter int          WORDS_PER_REGION = 64,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter logic [31:0] REGION_STRIDE    = 32'h0000_0100,
  parameter int          WAIT_STATES      = 0,
  parameter logic [7:0]  RO_MASK          = 8'h00
) (
  input  logic        h_clk,
  input  logic        h_resetn,
  input  logic [31:0] h_addr,
  input  logic [2:0]  h_burst,
  input  logic [2:0]  h_size,
  input  logic [1:0]  h_trans,
  input  logic [31:0] h_wdata,
  input  logic [3:0]  h_wstrb,
  input  logic        h_write,
  output logic [31:0] h_rdata,
  output logic        h_ready,
  output logic        h_resp,
  output logic [1:0]  dbg_state
);

  localparam int RSH   = $clog2(REGION_STRIDE);
  localparam int WW    = $clog2(WORDS_PER_REGION);
  localparam int RW    = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int IW    = RW + WW;
  localparam int DEPTH = NUM_REGIONS * WORDS_PER_REGION;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic            dp_valid;
  logic            dp_write;
  logic [IW-1:0]   dp_idx;
  logic [3:0]      dp_mask;
  logic [2:0]      wait_cnt;

  logic [31:0]     off;
  logic [31:0]     region_full;
  logic [31:0]     word_full;
  logic            unmapped;
  logic            misalign;
  logic            ro_hit;
  logic            illegal;
  logic            accept;
  logic [3:0]      acc_mask;
  logic [IW-1:0]   acc_idx;
  logic            commit_now;
  logic [3:0]      eff_strb;
  logic [IW-1:0]   rd_idx;
  logic [31:0]     rd_val;

  // Burst type has no effect: SEQ beats are decoded exactly like NONSEQ.
  logic unused_burst;
  assign unused_burst = ^h_burst;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  // Address-phase decode and legality
  always_comb begin
    off         = h_addr - BASE_ADDR;
    region_full = off >> RSH;
    word_full   = (off & (REGION_STRIDE - 32'd1)) >> 2;
    unmapped    = (h_addr < BASE_ADDR) ||
                  (region_full >= 32'(NUM_REGIONS)) ||
                  (word_full >= 32'(WORDS_PER_REGION));
    misalign    = ((h_size == 3'd1) && h_addr[0]) ||
                  ((h_size == 3'd2) && (h_addr[1:0] != 2'b00));
    ro_hit      = h_write && RO_MASK[region_full[2:0]];
    illegal     = unmapped || (h_size > 3'd2) || misalign || ro_hit;
    acc_idx     = {region_full[RW-1:0], word_full[WW-1:0]};
    case (h_size)
      3'd0:    acc_mask = 4'b0001 << h_addr[1:0];
      3'd1:    acc_mask = 4'b0011 << h_addr[1:0];
      default: acc_mask = 4'b1111;
    endcase
  end

  // Handshake: an address phase is taken on a rising edge only when h_ready=1 and
  // h_trans is NONSEQ/SEQ; its data phase ends on the first later edge with h_ready=1.
  assign accept     = h_ready && h_trans[1];
  assign commit_now = h_ready && dp_valid && dp_write;
  assign eff_strb   = h_wstrb & dp_mask;

  // Read source; forwards a write committing on the same edge so back-to-back RAW sees new data.
  always_comb begin
    rd_idx = (state == S_WAIT) ? dp_idx : acc_idx;
    rd_val = mem[rd_idx];
    if (commit_now && (dp_idx == rd_idx)) rd_val = merge_bytes(rd_val, h_wdata, eff_strb);
  end

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit_now) begin
      mem[dp_idx] <= merge_bytes(mem[dp_idx], h_wdata, eff_strb);
    end
  end

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      state    <= S_IDLE;
      h_ready  <= 1'b1;
      h_resp   <= 1'b0;
      h_rdata  <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_mask  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          if (accept && !illegal) begin
            dp_valid <= 1'b1;
            dp_write <= h_write;
            dp_idx   <= acc_idx;
            dp_mask  <= acc_mask;
            h_resp   <= 1'b0;
            if (WAIT_STATES == 0) begin
              state   <= S_IDLE;
              h_ready <= 1'b1;
              if (!h_write) h_rdata <= rd_val;
            end else begin
              state    <= S_WAIT;
              h_ready  <= 1'b0;
              wait_cnt <= 3'(WAIT_STATES);
            end
          end else if (accept) begin
            dp_valid <= 1'b0;
            state    <= S_ERR1;
            h_ready  <= 1'b0;
            h_resp   <= 1'b1;
          end else begin
            dp_valid <= 1'b0;
            state    <= S_IDLE;
            h_ready  <= 1'b1;
            h_resp   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd1) begin
            state   <= S_IDLE;
            h_ready <= 1'b1;
            if (!dp_write) h_rdata <= rd_val;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          h_ready <= 1'b1;
          h_resp  <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          h_ready <= 1'b1;
          h_resp  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ahb_multi_region_slave.sv
// Directed bench for ahb_multi_region_slave: zero-wait instance (region 1 read-only) and a
// two-wait-state instance, sharing one bus driver; a monitor checks completions against a queue.
module tb_ahb_multi_region_slave;

  typedef struct packed {
    logic        is_read;
    logic        resp;
    logic [2:0]  lows;
    logic [31:0] data;
  } exp_t;

  logic        h_clk = 1'b0;
  logic        h_resetn = 1'b0;
  logic [31:0] h_addr = '0;
  logic [2:0]  h_burst = '0;
  logic [2:0]  h_size = '0;
  logic [1:0]  h_trans = '0;
  logic [31:0] h_wdata = '0;
  logic [3:0]  h_wstrb = '0;
  logic        h_write = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  cur_ws = 3'd0;

  logic [1:0]  trans0, trans2;
  logic [31:0] rdata0, rdata2, rdata_s;
  logic        ready0, ready2, ready_s;
  logic        resp0, resp2, resp_s;
  logic [1:0]  dbg0, dbg2;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  logic dp_act = 1'b0;
  logic err_low = 1'b0;
  int   lows = 0;

  assign trans0  = sel ? 2'b00 : h_trans;
  assign trans2  = sel ? h_trans : 2'b00;
  assign rdata_s = sel ? rdata2 : rdata0;
  assign ready_s = sel ? ready2 : ready0;
  assign resp_s  = sel ? resp2 : resp0;

  ahb_multi_region_slave #(.WAIT_STATES(0), .RO_MASK(8'h02)) dut0 (
    .h_clk(h_clk), .h_resetn(h_resetn), .h_addr(h_addr), .h_burst(h_burst),
    .h_size(h_size), .h_trans(trans0), .h_wdata(h_wdata), .h_wstrb(h_wstrb),
    .h_write(h_write), .h_rdata(rdata0), .h_ready(ready0), .h_resp(resp0),
    .dbg_state(dbg0)
  );

  ahb_multi_region_slave #(.WAIT_STATES(2), .RO_MASK(8'h00)) dut2 (
    .h_clk(h_clk), .h_resetn(h_resetn), .h_addr(h_addr), .h_burst(h_burst),
    .h_size(h_size), .h_trans(trans2), .h_wdata(h_wdata), .h_wstrb(h_wstrb),
    .h_write(h_write), .h_rdata(rdata2), .h_ready(ready2), .h_resp(resp2),
    .dbg_state(dbg2)
  );

  // clock / reset
  always #5 h_clk = ~h_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, n_vec, act, req);
    end
  endtask

  // driver: present an address phase, hold it until taken, then drive its write data
  task automatic issue(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input logic err,
                       input logic [31:0] rdexp, input logic [1:0] trans);
    exp_t e;
    int   guard;
    logic r;
    guard   = 0;
    h_addr  = addr;
    h_size  = size;
    h_write = wr;
    h_trans = trans;
    h_burst = 3'b001;
    e.is_read = !wr;
    e.resp    = err;
    e.lows    = err ? 3'd1 : cur_ws;
    e.data    = rdexp;
    exp_q.push_back(e);
    do begin
      @(negedge h_clk);
      r = ready_s;
      @(posedge h_clk);
      #1;
      guard++;
    end while (!r && guard < 20);
    if (!r) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout addr %h: got h_ready=0 for 20 cycles, expected 1", addr);
    end
    h_wdata = wdata;
    h_wstrb = wstrb;
    h_trans = 2'b00;
    h_write = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d,
                    input logic [3:0] strb, input logic err);
    issue(addr, size, 1'b1, d, strb, err, 32'h0, 2'b10);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] x,
                    input logic err);
    issue(addr, size, 1'b0, 32'h0, 4'h0, err, x, 2'b10);
  endtask

  task automatic settle();
    repeat (3) begin
      @(posedge h_clk);
      #1;
    end
  endtask

  // monitor / scoreboard
  always @(negedge h_clk) begin
    if (!h_resetn) begin
      dp_act  = 1'b0;
      lows    = 0;
      err_low = 1'b0;
    end else begin
      if (dp_act) begin
        if (!ready_s) begin
          lows++;
          if (resp_s) err_low = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_completion: got a data phase end, expected none");
          end else begin
            mon_e = exp_q.pop_front();
            check("resp", 32'(resp_s), 32'(mon_e.resp));
            check("wait_cycles", 32'(lows), 32'(mon_e.lows));
            if (mon_e.resp) check("err_first_cycle_resp", 32'(err_low), 32'd1);
            else if (mon_e.is_read) check("rdata", rdata_s, mon_e.data);
          end
          dp_act = 1'b0;
        end
      end
      if (ready_s && h_trans[1]) begin
        dp_act  = 1'b1;
        lows    = 0;
        err_low = 1'b0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge h_clk);
    #1;
    h_resetn = 1'b1;
    check("rst_ready0", 32'(ready0), 32'd1);
    check("rst_resp0", 32'(resp0), 32'd0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_ready2", 32'(ready2), 32'd1);

    // zero-wait instance, region 1 read-only
    sel = 1'b0;
    cur_ws = 3'd0;
    wr(32'h004, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(32'h004, 3'd2, 32'hDEADBEEF, 1'b0);
    wr(32'h002, 3'd0, 32'hFFA5FFFF, 4'hF, 1'b0);
    rd(32'h000, 3'd2, 32'h00A50000, 1'b0);
    wr(32'h001, 3'd1, 32'hFFFFFFFF, 4'hF, 1'b1);
    rd(32'h000, 3'd2, 32'h00A50000, 1'b0);
    wr(32'h100, 3'd2, 32'h12345678, 4'hF, 1'b1);
    rd(32'h100, 3'd2, 32'h00000000, 1'b0);
    rd(32'h400, 3'd2, 32'h0, 1'b1);
    rd(32'h008, 3'd3, 32'h0, 1'b1);
    rd(32'h004, 3'd2, 32'hDEADBEEF, 1'b0);
    wr(32'h004, 3'd2, 32'h00000000, 4'h0, 1'b0);
    wr(32'h006, 3'd1, 32'h1234FFFF, 4'hF, 1'b0);
    rd(32'h004, 3'd2, 32'h1234BEEF, 1'b0);
    rd(32'h005, 3'd0, 32'h1234BEEF, 1'b0);
    wr(32'h00A, 3'd2, 32'h11111111, 4'hF, 1'b1);
    issue(32'h3FC, 3'd2, 1'b1, 32'hA5A55A5A, 4'hF, 1'b0, 32'h0, 2'b11);
    issue(32'h3FC, 3'd2, 1'b0, 32'h0, 4'h0, 1'b0, 32'hA5A55A5A, 2'b11);
    settle();
    check("queue_drained_dut0", 32'(exp_q.size()), 32'd0);

    // two-wait-state instance
    sel = 1'b1;
    cur_ws = 3'd2;
    settle();
    wr(32'h104, 3'd2, 32'hCAFEF00D, 4'hF, 1'b0);
    rd(32'h104, 3'd2, 32'hCAFEF00D, 1'b0);
    rd(32'h500, 3'd2, 32'h0, 1'b1);
    rd(32'h104, 3'd2, 32'hCAFEF00D, 1'b0);
    wr(32'h108, 3'd2, 32'h87654321, 4'hF, 1'b0);
    // now in the first wait cycle of that write: abort it with reset
    #2;
    h_resetn = 1'b0;
    #1;
    check("midreset_ready", 32'(ready2), 32'd1);
    check("midreset_resp", 32'(resp2), 32'd0);
    check("midreset_rdata", rdata2, 32'h0);
    check("midreset_state", 32'(dbg2), 32'd0);
    exp_q.delete();
    @(posedge h_clk);
    #1;
    h_resetn = 1'b1;
    rd(32'h108, 3'd2, 32'h00000000, 1'b0);
    rd(32'h104, 3'd2, 32'h00000000, 1'b0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge h_clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
    end
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
